// File: rtl/phy_link_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// SFP lane bring-up / recovery sequencer.
package phy_link_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_GX   = 3'd1,
    WAIT_LOCK = 3'd2,
    LINK_UP   = 3'd3,
    RETRY     = 3'd4
  } phy_link_state_t;

  localparam int unsigned DEF_RST_HOLD_CYC     = 16;
  localparam int unsigned DEF_GX_TIMEOUT_CYC   = 65536;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_ERR_WINDOW_CYC   = 8192;
  localparam int unsigned DEF_ERR_THRESH       = 16;
  localparam int unsigned DEF_RETRY_W          = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_link_timer.sv
// Clearable, enabled up-counter with a terminal-count flag; either holds at
// the terminal value or wraps back to zero.
module phy_link_timer #(
  parameter int unsigned W    = 8,
  parameter bit          WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == tc_val_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (tc_o) cnt_d = WRAP ? '0 : cnt_q;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phy_link_ctrl.sv
// Link bring-up / recovery sequencer for one SFP lane: transceiver reset,
// pcs_rx lock qualification, pcs_tx release, error-burst and lock-loss retry.
module phy_link_ctrl
  import phy_link_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int unsigned GX_TIMEOUT_CYC   = DEF_GX_TIMEOUT_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned ERR_WINDOW_CYC   = DEF_ERR_WINDOW_CYC,
  parameter int unsigned ERR_THRESH       = DEF_ERR_THRESH,
  parameter int unsigned RETRY_W          = DEF_RETRY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               loopback_req_i,
  input  logic               gx_tx_ready_i,
  input  logic               gx_rx_ready_i,
  input  logic               pcs_signal_v_i,
  input  logic               pcs_err_v_i,
  output logic               gx_reset_o,
  output logic               pcs_rx_nreset_o,
  output logic               pcs_tx_nreset_o,
  output logic               loopback_en_o,
  output logic               link_up_o,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int unsigned TMR_W = $clog2(max3(RST_HOLD_CYC, GX_TIMEOUT_CYC, LOCK_TIMEOUT_CYC) + 1);
  localparam int unsigned WIN_W = $clog2(ERR_WINDOW_CYC + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

  // Terminal counts are N-1 so the exit happens on the Nth cycle in the state.
  localparam logic [TMR_W-1:0] HOLD_TC = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GX_TC   = TMR_W'(GX_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_TC = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_TC  = WIN_W'(ERR_WINDOW_CYC - 1);
  localparam logic [STB_W-1:0] STB_TGT = STB_W'(LOCK_STABLE_CYC);
  localparam logic [ERR_W-1:0] ERR_TGT = ERR_W'(ERR_THRESH);

  phy_link_state_t    state_q, state_d;
  logic [STB_W-1:0]   stable_q, stable_d, stable_inc;
  logic [ERR_W-1:0]   err_q, err_d, err_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lb_req_q;
  logic [TMR_W-1:0]   tmr_tc_val;
  logic               tmr_tc, win_tc, entry, gx_ok, lock_done, err_hit;

  assign gx_ok      = gx_tx_ready_i & gx_rx_ready_i;
  assign entry      = (state_d != state_q);
  assign stable_inc = stable_q + 1'b1;
  // An error on the window's last cycle starts the new window's count.
  assign err_inc    = (win_tc ? '0 : err_q) + ERR_W'(pcs_err_v_i);
  assign lock_done  = pcs_signal_v_i && (stable_inc == STB_TGT);
  assign err_hit    = (err_inc == ERR_TGT);

  always_comb begin
    tmr_tc_val = '0;
    case (state_q)
      RST_HOLD:  tmr_tc_val = HOLD_TC;
      WAIT_GX:   tmr_tc_val = GX_TC;
      WAIT_LOCK: tmr_tc_val = LOCK_TC;
      default:   tmr_tc_val = '0;
    endcase
  end

  phy_link_timer #(.W(TMR_W), .WRAP(1'b0)) u_state_tmr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (entry),
    .en_i     ((state_q == RST_HOLD) ? en_i : 1'b1),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  phy_link_timer #(.W(WIN_W), .WRAP(1'b1)) u_win_tmr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (entry),
    .en_i     (state_q == LINK_UP),
    .tc_val_i (WIN_TC),
    .tc_o     (win_tc)
  );

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = RST_HOLD;
    end else begin
      case (state_q)
        RST_HOLD:  if (tmr_tc) state_d = WAIT_GX;
        WAIT_GX: begin
          if (gx_ok)       state_d = WAIT_LOCK;
          else if (tmr_tc) state_d = RETRY;
        end
        WAIT_LOCK: begin
          if (!gx_ok)         state_d = RETRY;
          else if (lock_done) state_d = LINK_UP;
          else if (tmr_tc)    state_d = RETRY;
        end
        LINK_UP:   if (!pcs_signal_v_i || !gx_ok || err_hit) state_d = RETRY;
        RETRY:     state_d = RST_HOLD;
        default:   state_d = RST_HOLD;
      endcase
    end
  end

  always_comb begin
    stable_d = '0;
    err_d    = '0;
    retry_d  = retry_q;
    if (!entry && state_q == WAIT_LOCK && pcs_signal_v_i) stable_d = stable_inc;
    if (!entry && state_q == LINK_UP) err_d = err_inc;
    if (state_q == RETRY && retry_q != '1) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RST_HOLD;
      stable_q <= '0;
      err_q    <= '0;
      retry_q  <= '0;
      lb_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      lb_req_q <= loopback_req_i;
    end
  end

  always_comb begin
    gx_reset_o      = 1'b1;
    pcs_rx_nreset_o = 1'b0;
    pcs_tx_nreset_o = 1'b0;
    loopback_en_o   = 1'b0;
    link_up_o       = 1'b0;
    case (state_q)
      WAIT_GX:   gx_reset_o = 1'b0;
      WAIT_LOCK: begin
        gx_reset_o      = 1'b0;
        pcs_rx_nreset_o = 1'b1;
      end
      LINK_UP: begin
        gx_reset_o      = 1'b0;
        pcs_rx_nreset_o = 1'b1;
        pcs_tx_nreset_o = 1'b1;
        loopback_en_o   = lb_req_q;
        link_up_o       = 1'b1;
      end
      default: gx_reset_o = 1'b1;
    endcase
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl: vector table for the happy path, then
// hand-written sequences for errors, GX loss, admin disable, reset, saturation.
module tb_phy_link_ctrl;

  logic clk = 1'b0;
  logic reset, en, lb, txr, rxr, sig, err;
  logic gx_rst, rx_nr, tx_nr, lbo, up;
  logic [2:0] st;
  logic [7:0] retry;

  logic rst2;
  logic s_gx_rst, s_rx_nr, s_tx_nr, s_lbo, s_up;
  logic [2:0] s_st;
  logic [1:0] s_retry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phy_link_ctrl #(
    .RST_HOLD_CYC(4), .GX_TIMEOUT_CYC(32), .LOCK_TIMEOUT_CYC(64),
    .LOCK_STABLE_CYC(8), .ERR_WINDOW_CYC(32), .ERR_THRESH(3), .RETRY_W(8)
  ) dut (
    .clk(clk), .reset(reset), .en_i(en), .loopback_req_i(lb),
    .gx_tx_ready_i(txr), .gx_rx_ready_i(rxr), .pcs_signal_v_i(sig), .pcs_err_v_i(err),
    .gx_reset_o(gx_rst), .pcs_rx_nreset_o(rx_nr), .pcs_tx_nreset_o(tx_nr),
    .loopback_en_o(lbo), .link_up_o(up), .state_o(st), .retry_cnt_o(retry)
  );

  // Readies never rise on this instance, so it only ever times out in WAIT_GX.
  phy_link_ctrl #(
    .RST_HOLD_CYC(4), .GX_TIMEOUT_CYC(32), .LOCK_TIMEOUT_CYC(64),
    .LOCK_STABLE_CYC(8), .ERR_WINDOW_CYC(32), .ERR_THRESH(3), .RETRY_W(2)
  ) dut_sat (
    .clk(clk), .reset(rst2), .en_i(1'b1), .loopback_req_i(1'b0),
    .gx_tx_ready_i(1'b0), .gx_rx_ready_i(1'b0), .pcs_signal_v_i(1'b0), .pcs_err_v_i(1'b0),
    .gx_reset_o(s_gx_rst), .pcs_rx_nreset_o(s_rx_nr), .pcs_tx_nreset_o(s_tx_nr),
    .loopback_en_o(s_lbo), .link_up_o(s_up), .state_o(s_st), .retry_cnt_o(s_retry)
  );

  // in  = {en, lb, tx_ready, rx_ready, signal_v, err_v}
  // exp = {state[2:0], gx_reset, rx_nreset, tx_nreset, loopback_en, link_up, retry[7:0]}
  typedef struct {
    int          n;
    logic [5:0]  in;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [15:0] outv();
    return {st, gx_rst, rx_nr, tx_nr, lbo, up, retry};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  initial begin
    bit seen_up;

    // Cycle numbers in comments count from the first clock with reset low.
    vecs[0]  = '{0,  6'b100000, {3'd0, 5'b10000, 8'd0}};  // cycle 0: reset state
    vecs[1]  = '{3,  6'b100000, {3'd0, 5'b10000, 8'd0}};  // cycle 3: still holding
    vecs[2]  = '{1,  6'b100000, {3'd1, 5'b00000, 8'd0}};  // cycle 4: gx_reset falls
    vecs[3]  = '{6,  6'b100000, {3'd1, 5'b00000, 8'd0}};  // cycle 10
    vecs[4]  = '{1,  6'b101100, {3'd2, 5'b01000, 8'd0}};  // cycle 11: WAIT_LOCK
    vecs[5]  = '{9,  6'b101100, {3'd2, 5'b01000, 8'd0}};  // cycle 20
    vecs[6]  = '{7,  6'b101110, {3'd2, 5'b01000, 8'd0}};  // cycle 27: 7 stable
    vecs[7]  = '{1,  6'b101110, {3'd3, 5'b01101, 8'd0}};  // cycle 28: link up
    vecs[8]  = '{1,  6'b111110, {3'd3, 5'b01111, 8'd0}};  // cycle 29: loopback lag
    vecs[9]  = '{1,  6'b101110, {3'd3, 5'b01101, 8'd0}};  // cycle 30
    vecs[10] = '{20, 6'b101110, {3'd3, 5'b01101, 8'd0}};  // cycle 50

    reset = 1'b1; rst2 = 1'b1;
    {en, lb, txr, rxr, sig, err} = 6'b100000;
    tick(3);
    reset = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 11; i++) begin
      {en, lb, txr, rxr, sig, err} = vecs[i].in;
      tick(vecs[i].n);
      chk($sformatf("vec%0d", i), {16'd0, outv()}, {16'd0, vecs[i].exp});
    end

    chk("sat_first_retry", {30'd0, s_retry}, 32'd1);

    // Link entered at 28, window wraps on 59: errors at 57,58 then 59 (new window), 62.
    tick(7); err = 1'b1;
    tick(3); err = 1'b0;
    tick(2); err = 1'b1;
    tick(1); err = 1'b0;
    tick(7);
    chk("err_split_wrap_up", {16'd0, outv()}, {16'd0, 3'd3, 5'b01101, 8'd0});

    // GX loss at 70.
    rxr = 1'b0;
    tick(1);
    chk("gx_loss_retry", {16'd0, outv()}, {16'd0, 3'd4, 5'b10000, 8'd0});
    tick(1);
    chk("gx_loss_hold", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd1});
    rxr = 1'b1;
    tick(12);
    chk("rebring_lock_84", {29'd0, st}, 32'd2);
    tick(1);
    chk("rebring_up_85", {16'd0, outv()}, {16'd0, 3'd3, 5'b01101, 8'd1});

    // Clean burst: errors at 90, 92, 94.
    tick(5); err = 1'b1;
    tick(1); err = 1'b0;
    tick(1); err = 1'b1;
    tick(1); err = 1'b0;
    tick(1); err = 1'b1;
    chk("burst_still_up_94", {31'd0, up}, 32'd1);
    tick(1); err = 1'b0;
    chk("burst_retry_95", {16'd0, outv()}, {16'd0, 3'd4, 5'b10000, 8'd1});
    tick(1);
    chk("burst_hold_96", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd2});

    // Admin disable mid WAIT_LOCK.
    sig = 1'b0;
    tick(5);
    chk("admin_wait_lock_101", {29'd0, st}, 32'd2);
    tick(5); en = 1'b0;
    tick(1);
    chk("admin_off_107", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd2});
    tick(3);
    chk("admin_off_held_110", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd2});
    en = 1'b1;

    // Lock flap: WAIT_LOCK from 115, 7 high / 1 low, timeout after 64 cycles.
    tick(5);
    chk("flap_wait_lock_115", {29'd0, st}, 32'd2);
    seen_up = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sig = ((i % 8) != 7);
      tick(1);
      if (st == 3'd3) seen_up = 1'b1;
    end
    chk("flap_never_up", {31'd0, seen_up}, 32'd0);
    chk("flap_retry_179", {16'd0, outv()}, {16'd0, 3'd4, 5'b10000, 8'd2});
    sig = 1'b0;
    tick(1);
    chk("flap_hold_180", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd3});

    // Bring up again, then synchronous reset while in LINK_UP.
    sig = 1'b1;
    tick(13);
    chk("up_again_193", {16'd0, outv()}, {16'd0, 3'd3, 5'b01101, 8'd3});
    lb = 1'b1;
    tick(2);
    chk("loopback_195", {16'd0, outv()}, {16'd0, 3'd3, 5'b01111, 8'd3});
    reset = 1'b1;
    tick(1);
    chk("reset_mid_link", {16'd0, outv()}, {16'd0, 3'd0, 5'b10000, 8'd0});
    reset = 1'b0;

    chk("sat_retry_stops_at_3", {30'd0, s_retry}, 32'd3);
    chk("sat_no_link", {31'd0, s_up}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
